// File: rtl/rf_bus_pkg.sv
// rtl/rf_bus_pkg.sv - shared widths, default register window and FSM state type for rf_bus_slave
package rf_bus_pkg;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 64;

    localparam logic [ADDR_W-1:0] DEF_BASE_ADDR = 16'h0110;
    localparam int                DEF_NUM_REGS  = 12;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD,
        RACK,
        ERR
    } rf_slv_state_t;
endpackage

// File: rtl/rf_addr_decode.sv
// rtl/rf_addr_decode.sv - combinational register-window hit check done at ADDR_W+1 bits
module rf_addr_decode
    import rf_bus_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR = DEF_BASE_ADDR,
    parameter int                NUM_REGS  = DEF_NUM_REGS
) (
    input  logic [ADDR_W-1:0] i_addr,
    output logic              o_in_range
);
    logic [ADDR_W:0] w_addr;
    logic [ADDR_W:0] w_lo;
    logic [ADDR_W:0] w_hi;

    // The extra top bit keeps a window that ends at the top of the map from wrapping to zero.
    assign w_addr     = {1'b0, i_addr};
    assign w_lo       = {1'b0, BASE_ADDR};
    assign w_hi       = w_lo + (ADDR_W + 1)'(NUM_REGS);
    assign o_in_range = (w_addr >= w_lo) && (w_addr < w_hi);
endmodule

// File: rtl/rf_bus_slave.sv
// rtl/rf_bus_slave.sv - bus slave front-end for the register file; RF_SLV_ERR_EN enables s_err reporting
module rf_bus_slave
    import rf_bus_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR = DEF_BASE_ADDR,
    parameter int                NUM_REGS  = DEF_NUM_REGS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_req,
    input  logic              s_wr,
    input  logic [ADDR_W-1:0] s_addr,
    input  logic [DATA_W-1:0] s_wdata,
    output logic              s_ack,
    output logic [DATA_W-1:0] s_rdata,
    output logic              s_err,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [ADDR_W-1:0] rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata
);
`ifdef RF_SLV_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    rf_slv_state_t     r_state;
    logic              r_ack;
    logic              r_err;
    logic              r_we;
    logic [DATA_W-1:0] r_rdata;
    logic [ADDR_W-1:0] r_waddr;
    logic [DATA_W-1:0] r_wdata;
    logic [ADDR_W-1:0] r_raddr;
    logic              w_in_range;

    rf_addr_decode #(
        .BASE_ADDR (BASE_ADDR),
        .NUM_REGS  (NUM_REGS)
    ) u_decode (
        .i_addr     (s_addr),
        .o_in_range (w_in_range)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_we    <= 1'b0;
            r_rdata <= '0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_raddr <= '0;
        end else begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            r_we  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (s_req) begin
                        if (!w_in_range) begin
                            r_state <= ERR;
                            r_ack   <= 1'b1;
                            r_err   <= ERR_EN;
                            if (!ERR_EN && !s_wr) begin
                                r_rdata <= '0;
                            end
                        end else if (s_wr) begin
                            r_state <= WR;
                            r_ack   <= 1'b1;
                            r_we    <= 1'b1;
                            r_waddr <= s_addr;
                            r_wdata <= s_wdata;
                        end else begin
                            r_state <= RD;
                            r_raddr <= s_addr;
                        end
                    end
                end
                RD: begin
                    r_rdata <= rf_rdata;
                    r_ack   <= 1'b1;
                    r_state <= RACK;
                end
                WR, RACK, ERR: r_state <= IDLE;
                default:       r_state <= IDLE;
            endcase
        end
    end

    // Reset landing in the ack/write cycle drops the transaction before the register file commits.
    assign s_ack    = r_ack & ~reset;
    assign s_err    = r_err & ~reset;
    assign rf_we    = r_we & ~reset;
    assign s_rdata  = r_rdata;
    assign rf_waddr = r_waddr;
    assign rf_wdata = r_wdata;
    assign rf_raddr = r_raddr;
endmodule
